// File: rtl/sram_ctrl.sv
// Single-port tag/data SRAM controller: IDLE -> ACCESS -> RESP handshake FSM.
// Optional SRAM_CTRL_FLUSH_EN adds a flush port that clears all valid bits.
module sram_ctrl (
  input  logic        clk,
  input  logic        rst_n,
`ifdef SRAM_CTRL_FLUSH_EN
  input  logic        flush,
`endif
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [3:0]  req_addr,
  input  logic [3:0]  req_tag,
  input  logic [7:0]  req_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_hit,
  output logic [7:0]  rsp_data,
  output logic        sram_we,
  output logic [15:0] sram_wl,
  output logic [3:0]  sram_tag_in,
  output logic [7:0]  sram_data_in,
  input  logic [3:0]  sram_tag_out,
  input  logic [7:0]  sram_data_out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef struct packed {
    logic       we;
    logic [3:0] addr;
    logic [3:0] tag;
    logic [7:0] data;
  } req_t;

  state_t      state_q;
  state_t      state_d;
  req_t        req_q;
  logic [15:0] valid_q;
  logic        rsp_hit_q;
  logic [7:0]  rsp_data_q;
  logic        accept;
  logic        flush_w;

`ifdef SRAM_CTRL_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    req_ready    = 1'b0;
    accept       = 1'b0;
    sram_we      = 1'b0;
    sram_wl      = '0;
    sram_tag_in  = '0;
    sram_data_in = '0;
    unique case (state_q)
      IDLE: begin
        req_ready = !flush_w;
        accept    = req_valid && !flush_w;
        if (accept) state_d = ACCESS;
      end
      ACCESS: begin
        sram_wl      = 16'h0001 << req_q.addr;
        sram_we      = req_q.we;
        sram_tag_in  = req_q.tag;
        sram_data_in = req_q.data;
        state_d      = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      req_q      <= '0;
      valid_q    <= '0;
      rsp_hit_q  <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        req_q <= '{we: req_we, addr: req_addr,
                   tag: req_tag, data: req_data};
      end
      if (state_q == IDLE && flush_w) begin
        valid_q <= '0;
      end
      if (state_q == ACCESS) begin
        if (req_q.we) begin
          valid_q[req_q.addr] <= 1'b1;
          rsp_hit_q           <= 1'b1;
          rsp_data_q          <= req_q.data;
        end else begin
          // array outputs are combinational from the wordline
          rsp_hit_q  <= valid_q[req_q.addr] &&
                        (sram_tag_out == req_q.tag);
          rsp_data_q <= sram_data_out;
        end
      end
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_hit   = rsp_hit_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl with an SRAM array model and a
// high-level valid/tag/data reference kept as plain arrays.
module tb_sram_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [3:0]  req_addr;
  logic [3:0]  req_tag;
  logic [7:0]  req_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_hit;
  logic [7:0]  rsp_data;
  logic        sram_we;
  logic [15:0] sram_wl;
  logic [3:0]  sram_tag_in;
  logic [7:0]  sram_data_in;
  logic [3:0]  sram_tag_out;
  logic [7:0]  sram_data_out;

  int n_chk = 0;
  int n_fail = 0;

  sram_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
`ifdef SRAM_CTRL_FLUSH_EN
    .flush         (flush),
`endif
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_addr      (req_addr),
    .req_tag       (req_tag),
    .req_data      (req_data),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_hit       (rsp_hit),
    .rsp_data      (rsp_data),
    .sram_we       (sram_we),
    .sram_wl       (sram_wl),
    .sram_tag_in   (sram_tag_in),
    .sram_data_in  (sram_data_in),
    .sram_tag_out  (sram_tag_out),
    .sram_data_out (sram_data_out)
  );

  always #5 clk = ~clk;

  // physical array: preloaded with a known pattern on the first edge
  bit         mem_init;
  logic [3:0] mem_tag  [16];
  logic [7:0] mem_data [16];

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 16; i++) begin
        mem_tag[i]  <= 4'(i) ^ 4'h5;
        mem_data[i] <= 8'(i * 37 + 11);
      end
      mem_init <= 1'b1;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (sram_we && sram_wl[i]) begin
          mem_tag[i]  <= sram_tag_in;
          mem_data[i] <= sram_data_in;
        end
      end
    end
  end

  always_comb begin
    sram_tag_out  = '0;
    sram_data_out = '0;
    for (int i = 0; i < 16; i++) begin
      if (sram_wl[i]) begin
        sram_tag_out  = sram_tag_out | mem_tag[i];
        sram_data_out = sram_data_out | mem_data[i];
      end
    end
  end

  // reference model of what the controller should report
  bit         ref_valid [16];
  logic [3:0] ref_tag   [16];
  logic [7:0] ref_data  [16];

  task automatic chk(input string name,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic clear_valid();
    for (int i = 0; i < 16; i++) ref_valid[i] = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input bit we, input logic [3:0] a,
                        input logic [3:0] t, input logic [7:0] d,
                        input int stall);
    logic       exp_hit;
    logic [7:0] exp_data;
    if (we) begin
      exp_hit  = 1'b1;
      exp_data = d;
    end else begin
      exp_hit  = ref_valid[a] && (ref_tag[a] == t);
      exp_data = ref_data[a];
    end
    chk("idle_req_ready", req_ready, 1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_tag   = t;
    req_data  = d;
    rsp_ready = 1'b0;
    tick();
    req_valid = 1'b0;
    chk("acc_wl", sram_wl, 32'h1 << a);
    chk("acc_we", sram_we, we);
    chk("acc_tag_in", sram_tag_in, t);
    chk("acc_data_in", sram_data_in, d);
    chk("acc_rsp_valid", rsp_valid, 0);
    chk("acc_req_ready", req_ready, 0);
    tick();
    for (int s = 0; s <= stall; s++) begin
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_hit", rsp_hit, exp_hit);
      chk("rsp_data", rsp_data, exp_data);
      chk("rsp_wl", sram_wl, 0);
      chk("rsp_we", sram_we, 0);
      chk("rsp_req_ready", req_ready, 0);
      if (s < stall) tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("post_rsp_valid", rsp_valid, 0);
    chk("post_req_ready", req_ready, 1);
    if (we) begin
      ref_valid[a] = 1'b1;
      ref_tag[a]   = t;
      ref_data[a]  = d;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    clear_valid();
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_hit", rsp_hit, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_wl", sram_wl, 0);
    chk("rst_we", sram_we, 0);
    chk("rst_tag_in", sram_tag_in, 0);
    chk("rst_data_in", sram_data_in, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_req_ready", req_ready, 1);
  endtask

  initial begin
    bit         we;
    logic [3:0] a;
    logic [3:0] t;
    rst_n     = 1'b0;
    flush     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_tag   = '0;
    req_data  = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ref_tag[i]  = 4'(i) ^ 4'h5;
      ref_data[i] = 8'(i * 37 + 11);
    end
    tick();
    tick();
    do_reset();

    do_req(1'b0, 4'd5, 4'd3, 8'h00, 0);
    do_req(1'b1, 4'd9, 4'hA, 8'h5C, 0);
    do_req(1'b0, 4'd9, 4'hA, 8'h11, 0);
    do_req(1'b0, 4'd9, 4'hB, 8'h22, 0);
    do_req(1'b1, 4'd15, 4'h1, 8'hF1, 0);
    do_req(1'b1, 4'd0, 4'h2, 8'h0E, 0);
    do_req(1'b0, 4'd15, 4'h1, 8'h00, 0);
    do_req(1'b0, 4'd0, 4'h2, 8'h00, 0);
    do_req(1'b0, 4'd9, 4'hA, 8'h33, 4);

    // tag of unwritten entry 12 matches the array, but it is not valid
    do_req(1'b0, 4'd12, 4'(12) ^ 4'h5, 8'h00, 0);

    // reset in the middle of a write's ACCESS cycle
    do_req(1'b0, 4'd3, 4'h0, 8'h00, 0);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 4'd3;
    req_tag   = 4'h7;
    req_data  = 8'hA5;
    tick();
    req_valid = 1'b0;
    chk("midacc_we", sram_we, 1);
    do_reset();
    do_req(1'b0, 4'd3, 4'h7, 8'h00, 0);
    do_req(1'b0, 4'd9, 4'hA, 8'h00, 0);

`ifdef SRAM_CTRL_FLUSH_EN
    do_req(1'b1, 4'd7, 4'h6, 8'h77, 0);
    flush     = 1'b1;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 4'd7;
    req_tag   = 4'h6;
    #1;
    chk("flush_req_ready", req_ready, 0);
    tick();
    flush     = 1'b0;
    req_valid = 1'b0;
    clear_valid();
    chk("flush_no_access", sram_wl, 0);
    chk("flush_ready_back", req_ready, 1);
    do_req(1'b0, 4'd7, 4'h6, 8'h00, 0);
`endif

    for (int n = 0; n < 40; n++) begin
      we = 1'($urandom_range(0, 1));
      a  = 4'($urandom_range(0, 15));
      t  = 4'($urandom_range(0, 15));
      if (!we && $urandom_range(0, 1) == 1) t = ref_tag[a];
      do_req(we, a, t, 8'($urandom), int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
